// File: rtl/serial_demux_if.sv
// Serial-in / word-out bundle for serial_demux: bit stream with resync in,
// completed word out with valid/ready and a drop indicator.
interface serial_demux_if #(
  parameter int NUM_LEVELS = 5,
  parameter int WIDTH      = 2**(NUM_LEVELS-1)
);
  logic                  in;
  logic                  in_valid;
  logic                  align;
  logic [NUM_LEVELS-2:0] sel;
  logic [WIDTH-1:0]      out;
  logic                  out_valid;
  logic                  out_ready;
  logic                  overrun;

  modport master (
    output in, in_valid, align, out_ready,
    input  sel, out, out_valid, overrun
  );

  modport slave (
    input  in, in_valid, align, out_ready,
    output sel, out, out_valid, overrun
  );
endinterface

// File: rtl/serial_demux.sv
// Serial-to-parallel demux: LSB-first bit capture into an accumulator indexed
// like the tree Mux sel, with a valid/ready holding register for finished words.
module serial_demux #(
  parameter int NUM_LEVELS = 5,
  parameter int WIDTH      = 2**(NUM_LEVELS-1)
) (
  input logic           clk,
  input logic           rst,
  serial_demux_if.slave bus
);
  localparam int SW = NUM_LEVELS-1;

  logic [SW-1:0]    sel_q, idx;
  logic [WIDTH-1:0] acc, out_q, word;
  logic             out_valid_q, overrun_q;
  logic             complete, take;

  // align redirects the current bit to index 0 and never finishes a word
  assign idx      = bus.align ? '0 : sel_q;
  assign complete = bus.in_valid && !bus.align && (sel_q == SW'(WIDTH-1));
  assign take     = complete && (!out_valid_q || bus.out_ready);
  assign word     = {bus.in, acc[WIDTH-2:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      acc <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++)
        if (bus.in_valid && idx == SW'(i)) acc[i] <= bus.in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q       <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      overrun_q <= complete && !take;
      if (bus.in_valid)   sel_q <= idx + SW'(1);
      else if (bus.align) sel_q <= '0;
      // a reload on completion wins over a plain consume
      if (take) begin
        out_q       <= word;
        out_valid_q <= 1'b1;
      end else if (out_valid_q && bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.sel       = sel_q;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_serial_demux.sv
// Bench for serial_demux (NUM_LEVELS=3, WIDTH=4): directed vector table for the
// corner cases, then a random stream checked through a word scoreboard.
module tb_serial_demux;
  localparam int NL = 3;
  localparam int W  = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_demux_if #(.NUM_LEVELS(NL), .WIDTH(W)) bus ();
  serial_demux #(.NUM_LEVELS(NL), .WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));

  typedef struct {
    logic       r, i, iv, al, rdy;
    logic [1:0] e_sel;
    logic [3:0] e_out;
    logic       e_ov, e_or;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] sb[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic v(input logic r, i, iv, al, rdy, input logic [1:0] s,
                   input logic [3:0] o, input logic ov, orn);
    vec_t t;
    t.r = r; t.i = i; t.iv = iv; t.al = al; t.rdy = rdy;
    t.e_sel = s; t.e_out = o; t.e_ov = ov; t.e_or = orn;
    vecs.push_back(t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;
    logic [3:0] bits;
    logic [3:0] got;

    rst = 1'b1; bus.in = 1'b0; bus.in_valid = 1'b0; bus.align = 1'b0; bus.out_ready = 1'b0;

    // reset with junk inputs
    v(1,1,1,1,1, 0,4'h0,0,0);
    v(1,0,1,0,0, 0,4'h0,0,0);
    // basic word 1,0,1,1 -> 4'b1101
    v(0,1,1,0,1, 1,4'h0,0,0);
    v(0,0,1,0,1, 2,4'h0,0,0);
    v(0,1,1,0,1, 3,4'h0,0,0);
    v(0,1,1,0,1, 0,4'hD,1,0);
    v(0,0,0,0,1, 0,4'hD,0,0);
    // gaps and stall: 0,1,1,(gap x3),0 -> 4'b0110
    v(0,0,1,0,0, 1,4'hD,0,0);
    v(0,1,1,0,0, 2,4'hD,0,0);
    v(0,1,1,0,0, 3,4'hD,0,0);
    v(0,1,0,0,0, 3,4'hD,0,0);
    v(0,1,0,0,0, 3,4'hD,0,0);
    v(0,1,0,0,0, 3,4'hD,0,0);
    v(0,0,1,0,0, 0,4'h6,1,0);
    v(0,0,0,0,0, 0,4'h6,1,0);
    v(0,0,0,0,1, 0,4'h6,0,0);
    v(0,0,0,0,0, 0,4'h6,0,0);
    // overrun: 0xA lands, 0x5 dropped
    v(0,0,1,0,0, 1,4'h6,0,0);
    v(0,1,1,0,0, 2,4'h6,0,0);
    v(0,0,1,0,0, 3,4'h6,0,0);
    v(0,1,1,0,0, 0,4'hA,1,0);
    v(0,1,1,0,0, 1,4'hA,1,0);
    v(0,0,1,0,0, 2,4'hA,1,0);
    v(0,1,1,0,0, 3,4'hA,1,0);
    v(0,0,1,0,0, 0,4'hA,1,1);
    v(0,0,0,0,0, 0,4'hA,1,0);
    v(0,0,0,0,1, 0,4'hA,0,0);
    // 0x3 held, then 0xC completes on the consume cycle
    v(0,1,1,0,0, 1,4'hA,0,0);
    v(0,1,1,0,0, 2,4'hA,0,0);
    v(0,0,1,0,0, 3,4'hA,0,0);
    v(0,0,1,0,0, 0,4'h3,1,0);
    v(0,0,1,0,0, 1,4'h3,1,0);
    v(0,0,1,0,0, 2,4'h3,1,0);
    v(0,1,1,0,0, 3,4'h3,1,0);
    v(0,1,1,0,1, 0,4'hC,1,0);
    v(0,0,0,0,0, 0,4'hC,1,0);
    // align with a bit mid-word -> 4'b1001
    v(0,1,1,0,1, 1,4'hC,0,0);
    v(0,1,1,0,1, 2,4'hC,0,0);
    v(0,1,1,1,1, 1,4'hC,0,0);
    v(0,0,1,0,1, 2,4'hC,0,0);
    v(0,0,1,0,1, 3,4'hC,0,0);
    v(0,1,1,0,1, 0,4'h9,1,0);
    // align at sel=3 must not complete; align alone zeroes sel
    v(0,1,1,0,0, 1,4'h9,1,0);
    v(0,1,1,0,0, 2,4'h9,1,0);
    v(0,1,1,0,0, 3,4'h9,1,0);
    v(0,0,1,1,0, 1,4'h9,1,0);
    v(0,0,0,1,0, 0,4'h9,1,0);
    // reset mid-word with a held word
    v(0,1,1,0,0, 1,4'h9,1,0);
    v(1,1,1,0,0, 0,4'h0,0,0);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst = vecs[k].r; bus.in = vecs[k].i; bus.in_valid = vecs[k].iv;
      bus.align = vecs[k].al; bus.out_ready = vecs[k].rdy;
      @(posedge clk); #1;
      chk($sformatf("vec%0d {sel,out,out_valid,overrun}", k),
          {25'd0, bus.sel, bus.out, bus.out_valid, bus.overrun},
          {25'd0, vecs[k].e_sel, vecs[k].e_out, vecs[k].e_ov, vecs[k].e_or});
    end

    // random stream, consumer always ready: every word must arrive, in order
    cnt = 0; bits = '0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      rst = 1'b0; bus.out_ready = 1'b1;
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in       = 1'($urandom);
      bus.align    = ($urandom_range(0, 31) == 0);
      if (bus.align) cnt = 0;
      if (bus.in_valid) begin
        if (!bus.align && cnt == 3) begin
          sb.push_back({bus.in, bits[2:0]});
          cnt = 0;
        end else begin
          bits[cnt] = bus.in;
          cnt++;
        end
      end
      @(posedge clk); #1;
      chk("rand overrun", {31'd0, bus.overrun}, 32'd0);
      chk("rand sel", {30'd0, bus.sel}, cnt);
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          chk("rand unexpected word", {28'd0, bus.out}, 32'hFFFF_FFFF);
        end else begin
          got = sb.pop_front();
          chk("rand word", {28'd0, bus.out}, {28'd0, got});
        end
      end
    end
    @(negedge clk); bus.in_valid = 1'b0; bus.align = 1'b0;
    @(posedge clk); #1;
    if (bus.out_valid && sb.size() != 0) begin
      got = sb.pop_front();
      chk("rand word tail", {28'd0, bus.out}, {28'd0, got});
    end
    chk("scoreboard drained", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
